// File: rtl/risc_pkg.sv
// Shared ISA definitions for the decoder and execution unit: opcodes, FSM states,
// instruction field positions and register read-set helpers.
package risc_pkg;

    typedef enum logic [3:0] {
        OpNop = 4'h0, OpAdd = 4'h1, OpSub = 4'h2, OpAnd = 4'h3,
        OpOr  = 4'h4, OpXor = 4'h5, OpInc = 4'h6, OpDec = 4'h7,
        OpNot = 4'h8, OpNeg = 4'h9, OpShr = 4'hA, OpShl = 4'hB,
        OpRor = 4'hC, OpRol = 4'hD, OpLd  = 4'hE, OpSt  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StStall = 2'd2,
        StHalt  = 2'd3
    } state_e;

    localparam int unsigned OpcodeHi = 15;
    localparam int unsigned OpcodeLo = 12;
    localparam int unsigned DstHi    = 11;
    localparam int unsigned DstLo    = 9;
    localparam int unsigned OpndaHi  = 8;
    localparam int unsigned OpndaLo  = 6;
    localparam int unsigned OpndbHi  = 5;
    localparam int unsigned OpndbLo  = 3;
    localparam int unsigned DmaddrHi = 3;
    localparam int unsigned DmaddrLo = 0;

    localparam logic [3:0] PcLast = 4'hF;

    // Decoded instruction as presented to the execution unit
    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] dst;
        logic [2:0] opnda;
        logic [2:0] opndb;
        logic [3:0] dmaddr;
    } issue_t;

    function automatic issue_t decode(logic [15:0] instr);
        issue_t d;
        d.opcode = instr[OpcodeHi:OpcodeLo];
        d.dst    = instr[DstHi:DstLo];
        d.opnda  = instr[OpndaHi:OpndaLo];
        d.opndb  = instr[OpndbHi:OpndbLo];
        d.dmaddr = instr[DmaddrHi:DmaddrLo];
        return d;
    endfunction

    function automatic logic reads_opnda(logic [3:0] op);
        return (op != OpNop) && (op != OpLd);
    endfunction

    function automatic logic reads_opndb(logic [3:0] op);
        return (op >= OpAdd) && (op <= OpXor);
    endfunction

endpackage

// File: rtl/risc_hazard.sv
// Load-use hazard detector: flags an incoming instruction that reads the
// destination of a load currently held in the issue registers.
module risc_hazard
    import risc_pkg::*;
(
    input  logic [3:0]  reg_opcode,
    input  logic [2:0]  reg_dst,
    input  logic [15:0] instr,
    output logic        stall
);

    issue_t in_dec;
    logic   hit_a;
    logic   hit_b;

    assign in_dec = decode(instr);
    assign hit_a  = reads_opnda(in_dec.opcode) && (in_dec.opnda == reg_dst);
    assign hit_b  = reads_opndb(in_dec.opcode) && (in_dec.opndb == reg_dst);
    assign stall  = (reg_opcode == OpLd) && (hit_a || hit_b);

endmodule

// File: rtl/risc_idecode.sv
// Instruction fetch/decode stage: walks a 16-entry program once per start,
// issuing registered decode fields and inserting one bubble on load-use hazards.
module risc_idecode
    import risc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] imem_data,
    output logic [3:0]  imem_addr,
    output logic [3:0]  opcode,
    output logic [2:0]  dstin,
    output logic [2:0]  opnda_addr,
    output logic [2:0]  opndb_addr,
    output logic [3:0]  dmaddrin,
    output logic        busy,
    output logic [7:0]  issue_cnt
);

    state_e     state_q;
    logic [3:0] pc_q;
    issue_t     issue_q;
    logic [7:0] cnt_q;
    logic       stall;

    risc_hazard u_hazard (
        .reg_opcode (issue_q.opcode),
        .reg_dst    (issue_q.dst),
        .instr      (imem_data),
        .stall      (stall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= 4'd0;
            issue_q <= '0;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                StIdle, StHalt: begin
                    issue_q <= '0;
                    if (start) begin
                        pc_q    <= 4'd0;
                        state_q <= StRun;
                    end
                end
                StRun, StStall: begin
                    // A stall bubble can only follow a real issue, so STALL never re-stalls
                    if ((state_q == StRun) && stall) begin
                        issue_q <= '0;
                        state_q <= StStall;
                    end else begin
                        issue_q <= decode(imem_data);
                        if (cnt_q != 8'hFF) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                        if (pc_q == PcLast) begin
                            state_q <= StHalt;
                        end else begin
                            pc_q    <= pc_q + 4'd1;
                            state_q <= StRun;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign opcode     = issue_q.opcode;
    assign dstin      = issue_q.dst;
    assign opnda_addr = issue_q.opnda;
    assign opndb_addr = issue_q.opndb;
    assign dmaddrin   = issue_q.dmaddr;
    assign busy       = (state_q == StRun) || (state_q == StStall);
    assign issue_cnt  = cnt_q;

endmodule

// File: tb/tb_risc_idecode.sv
// Randomized bench for risc_idecode: expected issue traces are derived per
// program from the ISA rules, plus literal checks on a directed program.
module tb_risc_idecode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] imem_data;
    logic [3:0]  imem_addr;
    logic [3:0]  opcode;
    logic [2:0]  dstin;
    logic [2:0]  opnda_addr;
    logic [2:0]  opndb_addr;
    logic [3:0]  dmaddrin;
    logic        busy;
    logic [7:0]  issue_cnt;

    logic [15:0] mem [0:15];

    int vectors = 0;
    int miscompares = 0;
    int model_cnt = 0;

    typedef struct {
        logic [3:0] op;
        logic [2:0] dst;
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] dm;
        logic [3:0] pc;
        logic       bsy;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_v;
    exp_t trace[$];
    logic chk_en = 1'b0;

    risc_idecode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_data  (imem_data),
        .imem_addr  (imem_addr),
        .opcode     (opcode),
        .dstin      (dstin),
        .opnda_addr (opnda_addr),
        .opndb_addr (opndb_addr),
        .dmaddrin   (dmaddrin),
        .busy       (busy),
        .issue_cnt  (issue_cnt)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_all(input exp_t e);
        check("opcode", 32'(opcode), 32'(e.op));
        check("dstin", 32'(dstin), 32'(e.dst));
        check("opnda_addr", 32'(opnda_addr), 32'(e.a));
        check("opndb_addr", 32'(opndb_addr), 32'(e.b));
        check("dmaddrin", 32'(dmaddrin), 32'(e.dm));
        check("imem_addr", 32'(imem_addr), 32'(e.pc));
        check("busy", 32'(busy), 32'(e.bsy));
        check("issue_cnt", 32'(issue_cnt), 32'(e.cnt));
    endtask

    // Compare process: outputs settle well before 2 time units after the edge
    always @(posedge clk) begin
        #2;
        if (chk_en) check_all(exp_v);
    end

    function automatic exp_t quiet(input logic [3:0] pc, input logic bsy, input int cnt);
        exp_t e;
        e.op = 4'd0; e.dst = 3'd0; e.a = 3'd0; e.b = 3'd0; e.dm = 4'd0;
        e.pc = pc; e.bsy = bsy; e.cnt = 8'(cnt);
        return e;
    endfunction

    // Register read sets by opcode number
    function automatic bit uses_a(input int op);
        return (op >= 1 && op <= 13) || op == 15;
    endfunction

    function automatic bit uses_b(input int op);
        return op >= 1 && op <= 5;
    endfunction

    // Expected per-edge output sequence for one pass through mem, starting after the start edge
    function automatic void build_trace();
        int prev_op;
        int prev_dst;
        exp_t e;
        trace.delete();
        prev_op = 0;
        prev_dst = 0;
        for (int p = 0; p < 16; p++) begin
            int w, op, dst, a, b;
            w   = int'(mem[p]);
            op  = w / 4096;
            dst = (w / 512) % 8;
            a   = (w / 64) % 8;
            b   = (w / 8) % 8;
            if (prev_op == 14 && ((uses_a(op) && a == prev_dst) || (uses_b(op) && b == prev_dst))) begin
                trace.push_back(quiet(4'(p), 1'b1, model_cnt));
            end
            if (model_cnt < 255) model_cnt++;
            e.op = 4'(op); e.dst = 3'(dst); e.a = 3'(a); e.b = 3'(b); e.dm = 4'(w % 16);
            e.pc  = (p == 15) ? 4'd15 : 4'(p + 1);
            e.bsy = (p != 15);
            e.cnt = 8'(model_cnt);
            trace.push_back(e);
            prev_op = op;
            prev_dst = dst;
        end
    endfunction

    task automatic load_directed();
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1E38;  // add d7,a0,b7
        mem[1] = 16'hE405;  // ld r2,[5]
        mem[2] = 16'h1688;  // add r3,r2,r1 -> load-use bubble
        mem[3] = 16'hE405;  // ld r2,[5]
        mem[4] = 16'h6840;  // inc r4,r1 -> no dependency
    endtask

    task automatic load_random();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            logic [2:0] d, a, b, lo;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = 4'hE;
            d  = 3'($urandom_range(0, 3));
            a  = 3'($urandom_range(0, 3));
            b  = 3'($urandom_range(0, 3));
            lo = 3'($urandom_range(0, 7));
            mem[i] = {op, d, a, b, lo};
        end
    endtask

    // Called at a negedge; returns at a negedge
    task automatic run_program(input bit directed);
        int cnt0;
        cnt0 = model_cnt;
        build_trace();
        start = 1'b1;
        exp_v = quiet(4'd0, 1'b1, cnt0);
        chk_en = 1'b1;
        for (int k = 0; k < trace.size(); k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 5) == 0);
            exp_v = trace[k];
            if (directed) begin
                @(posedge clk);
                #3;
                if (k == 0) begin
                    check("first_opcode", 32'(opcode), 32'h1);
                    check("first_dstin", 32'(dstin), 32'h7);
                    check("first_opnda", 32'(opnda_addr), 32'h0);
                    check("first_opndb", 32'(opndb_addr), 32'h7);
                    check("first_cnt", 32'(issue_cnt), 32'h1);
                end else if (k == 2) begin
                    check("bubble_opcode", 32'(opcode), 32'h0);
                    check("bubble_pc_held", 32'(imem_addr), 32'h2);
                end else if (k == 3) begin
                    check("after_bubble_opcode", 32'(opcode), 32'h1);
                    check("after_bubble_dstin", 32'(dstin), 32'h3);
                    check("after_bubble_cnt", 32'(issue_cnt), 32'h3);
                end else if (k == 5) begin
                    check("no_stall_inc_opcode", 32'(opcode), 32'h6);
                    check("no_stall_inc_cnt", 32'(issue_cnt), 32'h5);
                end
            end
        end
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            start = 1'b0;
            exp_v = quiet(4'hF, 1'b0, model_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        load_directed();
        #12;
        check_all(quiet(4'd0, 1'b0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        run_program(1'b1);
        for (int r = 0; r < 18; r++) begin
            load_random();
            run_program(1'b0);
        end
        chk_en = 1'b0;
        check("cnt_saturated", 32'(issue_cnt), 32'hFF);

        // Asynchronous reset while in STALL
        load_directed();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_stall_busy", 32'(busy), 32'h1);
        check("pre_reset_stall_pc", 32'(imem_addr), 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        check_all(quiet(4'd0, 1'b0, 0));
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_program(1'b1);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
